// File: rtl/bloom_req_arbiter.sv
// Shares one Bloom filter update port between two tuple extractors (round-robin) and runs full-table clear sweeps.
// Define BLOOM_ARB_STATS_EN to build the per-port grant counters; otherwise gnt_cnt0/gnt_cnt1 read 0.
module bloom_req_arbiter #(
    parameter int HASH_BITS = 19,
    parameter int TUPLE_W   = 96
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_wr,
    output logic                 req0_rdy,
    input  logic [HASH_BITS-1:0] req0_idx0,
    input  logic [HASH_BITS-1:0] req0_idx1,
    input  logic [TUPLE_W-1:0]   req0_tuple,
    input  logic                 req0_is_ack,

    input  logic                 req1_wr,
    output logic                 req1_rdy,
    input  logic [HASH_BITS-1:0] req1_idx0,
    input  logic [HASH_BITS-1:0] req1_idx1,
    input  logic [TUPLE_W-1:0]   req1_tuple,
    input  logic                 req1_is_ack,

    input  logic                 core_rdy,
    output logic                 core_wr,
    output logic                 core_clr,
    output logic [HASH_BITS-1:0] core_idx0,
    output logic [HASH_BITS-1:0] core_idx1,
    output logic [TUPLE_W-1:0]   core_tuple,
    output logic                 core_is_ack,
    output logic                 core_src,

    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 clear_done,

    output logic [31:0]          gnt_cnt0,
    output logic [31:0]          gnt_cnt1
);

    localparam logic [HASH_BITS-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SWEEP,
        ST_SWEEP_GAP
    } state_t;

    state_t state, state_nx;

    logic [1:0]           hold_valid;
    logic [HASH_BITS-1:0] hold_idx0 [2];
    logic [HASH_BITS-1:0] hold_idx1 [2];
    logic [TUPLE_W-1:0]   hold_tuple [2];
    logic                 hold_is_ack [2];

    logic                 last_gnt;
    logic                 clear_pending;
    logic [HASH_BITS-1:0] addr;

    logic [1:0] capture;
    logic [1:0] grant_mask;
    logic       grant_en;
    logic       grant_port;
    logic       sweep_start;
    logic       clr_issue;
    logic       addr_inc;
    logic       sweep_end;

    // A write while the port is full is a protocol error and is dropped here.
    assign capture    = {req1_wr, req0_wr} & ~hold_valid;
    assign grant_mask = grant_en ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

    assign req0_rdy   = ~hold_valid[0];
    assign req1_rdy   = ~hold_valid[1];
    assign clear_busy = clear_pending;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        grant_en    = 1'b0;
        grant_port  = 1'b0;
        sweep_start = 1'b0;
        clr_issue   = 1'b0;
        addr_inc    = 1'b0;
        sweep_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A clear arriving in the same cycle as a possible grant takes priority.
                if (clear_pending || clear_req) begin
                    sweep_start = 1'b1;
                    state_nx    = ST_SWEEP;
                end else if (core_rdy && (hold_valid != 2'b00)) begin
                    grant_en   = 1'b1;
                    grant_port = (hold_valid == 2'b11) ? ~last_gnt : hold_valid[1];
                    state_nx   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = ST_IDLE;
            ST_SWEEP: begin
                if (core_rdy) begin
                    clr_issue = 1'b1;
                    state_nx  = ST_SWEEP_GAP;
                end
            end
            ST_SWEEP_GAP: begin
                if (addr == ADDR_LAST) begin
                    sweep_end = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    addr_inc = 1'b1;
                    state_nx = ST_SWEEP;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            hold_valid    <= 2'b00;
            last_gnt      <= 1'b1;
            clear_pending <= 1'b0;
            addr          <= '0;
        end else begin
            state      <= state_nx;
            hold_valid <= (hold_valid | capture) & ~grant_mask;
            if (grant_en)
                last_gnt <= grant_port;
            if (sweep_end)
                clear_pending <= 1'b0;
            else if (clear_req)
                clear_pending <= 1'b1;
            if (sweep_start)
                addr <= '0;
            else if (addr_inc)
                addr <= addr + HASH_BITS'(1);
        end
    end

    // NOTE: hold payload is storage qualified by hold_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture[0]) begin
            hold_idx0[0]   <= req0_idx0;
            hold_idx1[0]   <= req0_idx1;
            hold_tuple[0]  <= req0_tuple;
            hold_is_ack[0] <= req0_is_ack;
        end
        if (capture[1]) begin
            hold_idx0[1]   <= req1_idx0;
            hold_idx1[1]   <= req1_idx1;
            hold_tuple[1]  <= req1_tuple;
            hold_is_ack[1] <= req1_is_ack;
        end
    end

    // Core command register: payload only moves on a grant or a clear issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_wr     <= 1'b0;
            core_clr    <= 1'b0;
            core_idx0   <= '0;
            core_idx1   <= '0;
            core_tuple  <= '0;
            core_is_ack <= 1'b0;
            core_src    <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            core_wr    <= grant_en;
            core_clr   <= clr_issue;
            clear_done <= sweep_end;
            if (grant_en) begin
                core_idx0   <= hold_idx0[grant_port];
                core_idx1   <= hold_idx1[grant_port];
                core_tuple  <= hold_tuple[grant_port];
                core_is_ack <= hold_is_ack[grant_port];
                core_src    <= grant_port;
            end else if (clr_issue) begin
                core_idx0   <= addr;
                core_idx1   <= '0;
                core_is_ack <= 1'b0;
                core_src    <= 1'b0;
            end
        end
    end

`ifdef BLOOM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (grant_en) begin
            if (grant_port)
                gnt_cnt1 <= gnt_cnt1 + 32'd1;
            else
                gnt_cnt0 <= gnt_cnt0 + 32'd1;
        end
    end
`else
    assign gnt_cnt0 = 32'h0;
    assign gnt_cnt1 = 32'h0;
`endif

endmodule

// File: tb/tb_bloom_req_arbiter.sv
// Self-checking bench for bloom_req_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_bloom_req_arbiter;

    localparam int HB = 4;
    localparam int TW = 96;
    localparam int VW = 2 * HB + TW + 72;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_wr, req1_wr, req0_rdy, req1_rdy;
    logic [HB-1:0] req0_idx0, req0_idx1, req1_idx0, req1_idx1;
    logic [TW-1:0] req0_tuple, req1_tuple;
    logic          req0_is_ack, req1_is_ack;
    logic          core_rdy, core_wr, core_clr, core_is_ack, core_src;
    logic [HB-1:0] core_idx0, core_idx1;
    logic [TW-1:0] core_tuple;
    logic          clear_req, clear_busy, clear_done;
    logic [31:0]   gnt_cnt0, gnt_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    bloom_req_arbiter #(.HASH_BITS(HB), .TUPLE_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req0_wr(req0_wr), .req0_rdy(req0_rdy), .req0_idx0(req0_idx0), .req0_idx1(req0_idx1),
        .req0_tuple(req0_tuple), .req0_is_ack(req0_is_ack),
        .req1_wr(req1_wr), .req1_rdy(req1_rdy), .req1_idx0(req1_idx0), .req1_idx1(req1_idx1),
        .req1_tuple(req1_tuple), .req1_is_ack(req1_is_ack),
        .core_rdy(core_rdy), .core_wr(core_wr), .core_clr(core_clr),
        .core_idx0(core_idx0), .core_idx1(core_idx1), .core_tuple(core_tuple),
        .core_is_ack(core_is_ack), .core_src(core_src),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: pending requests per port, a "one idle cycle after any command" rule,
    // and the sweep tracked as the next address still to be cleared (-1 when no sweep).
    typedef struct packed {
        logic          v;
        logic [HB-1:0] i0;
        logic [HB-1:0] i1;
        logic [TW-1:0] t;
        logic          a;
    } hold_t;

    hold_t         mh [2];
    logic          m_last, m_cool, m_pend;
    int            m_next;
    int unsigned   m_cnt [2];
    logic          e_wr, e_clr, e_ack, e_src, e_done;
    logic [HB-1:0] e_i0, e_i1;
    logic [TW-1:0] e_tup;
    logic          cap0, cap1, pend_before;
    int            p;

    always @(posedge clk) begin
        if (reset) begin
            mh[0] = '0; mh[1] = '0;
            m_last = 1'b1; m_cool = 1'b0; m_pend = 1'b0; m_next = -1;
            m_cnt[0] = 0; m_cnt[1] = 0;
            e_wr = 0; e_clr = 0; e_ack = 0; e_src = 0; e_done = 0;
            e_i0 = '0; e_i1 = '0; e_tup = '0;
        end else begin
            cap0 = req0_wr && !mh[0].v;
            cap1 = req1_wr && !mh[1].v;
            pend_before = m_pend;
            e_wr = 0; e_clr = 0; e_done = 0;
            if (m_cool) begin
                m_cool = 0;
                if (m_next == (1 << HB)) begin
                    e_done = 1; m_pend = 0; m_next = -1;
                end
            end else if (m_next >= 0) begin
                if (core_rdy) begin
                    e_clr = 1; e_i0 = HB'(m_next); e_i1 = '0; e_ack = 0; e_src = 0;
                    m_next++; m_cool = 1;
                end
            end else if (m_pend || clear_req) begin
                m_next = 0;
            end else if (core_rdy && (mh[0].v || mh[1].v)) begin
                if (mh[0].v && mh[1].v) p = m_last ? 0 : 1;
                else p = mh[1].v ? 1 : 0;
                e_wr = 1; e_i0 = mh[p].i0; e_i1 = mh[p].i1; e_tup = mh[p].t; e_ack = mh[p].a;
                e_src = (p == 1); m_last = (p == 1); mh[p].v = 0; m_cnt[p]++; m_cool = 1;
            end
            if (clear_req && !pend_before) m_pend = 1;
            if (cap0) mh[0] = {1'b1, req0_idx0, req0_idx1, req0_tuple, req0_is_ack};
            if (cap1) mh[1] = {1'b1, req1_idx0, req1_idx1, req1_tuple, req1_is_ack};
        end
    end

    task automatic idle_inputs();
        req0_wr = 0; req1_wr = 0; clear_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle_inputs(); core_rdy = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic set_req(input int port, input logic [HB-1:0] i0, input logic [HB-1:0] i1,
                           input logic [TW-1:0] t, input logic a);
        if (port == 0) begin
            req0_wr = 1; req0_idx0 = i0; req0_idx1 = i1; req0_tuple = t; req0_is_ack = a;
        end else begin
            req1_wr = 1; req1_idx0 = i0; req1_idx1 = i1; req1_tuple = t; req1_is_ack = a;
        end
    endtask

    function automatic logic [TW-1:0] rand_tuple();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1; idle_inputs(); core_rdy = 1;
        @(negedge clk);
        n_tests++;
        if ({core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src, clear_busy, clear_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_core: wr=%b clr=%b idx0=%h idx1=%h tuple=%h ack=%b src=%b busy=%b done=%b, required all 0",
                     core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src, clear_busy, clear_done);
        end
        n_tests++;
        if ({req0_rdy, req1_rdy} !== 2'b11) begin
            n_fail++; $display("FAIL reset_rdy: got %b%b, required 11", req0_rdy, req1_rdy);
        end
        n_tests++;
        if ({gnt_cnt0, gnt_cnt1} !== 64'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d, required 0/0", gnt_cnt0, gnt_cnt1);
        end
        reset = 0;
    endtask

    task automatic test_single();
        logic [TW-1:0] t;
        do_reset();
        t = rand_tuple();
        set_req(0, 4'h4, 4'hC, t, 1'b1);
        @(negedge clk);
        idle_inputs();
        n_tests++;
        if (req0_rdy !== 1'b0 || core_wr !== 1'b0) begin
            n_fail++; $display("FAIL single_hold: rdy0=%b core_wr=%b, required 0/0", req0_rdy, core_wr);
        end
        @(negedge clk);
        n_tests++;
        if ({core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src, req0_rdy} !==
            {1'b1, 1'b0, 4'h4, 4'hC, t, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: wr=%b clr=%b idx0=%h idx1=%h tuple=%h ack=%b src=%b rdy0=%b, required 1 0 4 c %h 1 0 1",
                     core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src, req0_rdy, t);
        end
        @(negedge clk);
        n_tests++;
        if (core_wr !== 1'b0 || core_idx0 !== 4'h4 || core_tuple !== t) begin
            n_fail++; $display("FAIL single_hold_out: wr=%b idx0=%h, required wr=0 idx0=4 held", core_wr, core_idx0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            set_req(0, 4'h1, 4'h2, rand_tuple(), 1'b0);
            set_req(1, 4'h9, 4'hA, rand_tuple(), 1'b1);
            @(negedge clk);
            idle_inputs();
            @(negedge clk);
            n_tests++;
            if (core_wr !== 1'b1 || core_src !== 1'b0 || core_idx0 !== 4'h1) begin
                n_fail++; $display("FAIL simul_first[%0d]: wr=%b src=%b idx0=%h, required 1 0 1", rep, core_wr, core_src, core_idx0);
            end
            @(negedge clk);
            @(negedge clk);
            n_tests++;
            if (core_wr !== 1'b1 || core_src !== 1'b1 || core_idx0 !== 4'h9 || core_is_ack !== 1'b1) begin
                n_fail++; $display("FAIL simul_second[%0d]: wr=%b src=%b idx0=%h ack=%b, required 1 1 9 1",
                                   rep, core_wr, core_src, core_idx0, core_is_ack);
            end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        core_rdy = 0;
        set_req(0, 4'h3, 4'h5, rand_tuple(), 1'b0);
        set_req(1, 4'h7, 4'hB, rand_tuple(), 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle_inputs();
            if (core_wr !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) bad++;
            if (c == 3) set_req(0, 4'hE, 4'hE, rand_tuple(), 1'b1);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL backpressure_stall: %0d bad cycles, required 0", bad);
        end
        core_rdy = 1;
        @(negedge clk);
        n_tests++;
        if (core_wr !== 1'b1 || core_src !== 1'b0 || core_idx0 !== 4'h3 || core_is_ack !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_g0: wr=%b src=%b idx0=%h ack=%b, required 1 0 3 0", core_wr, core_src, core_idx0, core_is_ack);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (core_wr !== 1'b1 || core_src !== 1'b1 || core_idx0 !== 4'h7) begin
            n_fail++; $display("FAIL backpressure_g1: wr=%b src=%b idx0=%h, required 1 1 7", core_wr, core_src, core_idx0);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (core_wr !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL backpressure_extra: %0d extra grants, required 0", bad);
        end
    endtask

    task automatic test_clear_sweep();
        int exp_addr, bad, wr_seen, rdy_bad;
        logic fin;
        logic [TW-1:0] t;
        do_reset();
        t = rand_tuple();
        exp_addr = 0; bad = 0; wr_seen = 0; rdy_bad = 0; fin = 0;
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        n_tests++;
        if (clear_busy !== 1'b1) begin
            n_fail++; $display("FAIL sweep_busy_rise: got %b, required 1", clear_busy);
        end
        for (int c = 0; c < 120 && !fin; c++) begin
            @(negedge clk);
            idle_inputs();
            if (core_clr) begin
                if (core_idx0 !== HB'(exp_addr) || core_idx1 !== '0 || core_src !== 1'b0 || core_is_ack !== 1'b0) bad++;
                exp_addr++;
            end
            if (core_wr) wr_seen++;
            if (c == 6 && req1_rdy !== 1'b0) rdy_bad++;
            if (clear_done) fin = 1;
            if (c == 5) set_req(1, 4'h6, 4'hD, t, 1'b1);
            if (c == 9) clear_req = 1;
        end
        n_tests++;
        if (!fin || exp_addr != 16 || bad != 0) begin
            n_fail++; $display("FAIL sweep_addrs: done=%b clears=%0d bad=%0d, required 1 16 0", fin, exp_addr, bad);
        end
        n_tests++;
        if (wr_seen != 0 || rdy_bad != 0 || clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL sweep_hold: wr_during=%0d rdy1_bad=%0d busy_at_done=%b, required 0 0 0", wr_seen, rdy_bad, clear_busy);
        end
        @(negedge clk);
        n_tests++;
        if (core_wr !== 1'b1 || core_src !== 1'b1 || core_idx0 !== 4'h6 || core_idx1 !== 4'hD || core_tuple !== t || clear_done !== 1'b0) begin
            n_fail++; $display("FAIL sweep_after_wr: wr=%b src=%b idx0=%h idx1=%h done=%b, required 1 1 6 d 0",
                               core_wr, core_src, core_idx0, core_idx1, clear_done);
        end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (core_clr !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sweep_no_rearm: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic found;
        int bad;
        do_reset();
        found = 0;
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            idle_inputs();
            if (core_clr === 1'b1 && core_idx0 === 4'h7) found = 1;
            if (c == 2) set_req(0, 4'h2, 4'h2, rand_tuple(), 1'b0);
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL midsweep_reach7: clear of addr 7 not seen within budget, required seen");
        end
        reset = 1;
        @(negedge clk);
        n_tests++;
        if ({core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src, clear_busy, clear_done} !== '0 ||
            {req0_rdy, req1_rdy} !== 2'b11) begin
            n_fail++; $display("FAIL midsweep_reset: wr=%b clr=%b idx0=%h busy=%b rdy=%b%b, required reset values",
                               core_wr, core_clr, core_idx0, clear_busy, req0_rdy, req1_rdy);
        end
        reset = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (core_clr !== 1'b0 || core_wr !== 1'b0 || clear_busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midsweep_after: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp0, exp1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_req((k < 5) ? 0 : 1, HB'(k), HB'(k + 1), rand_tuple(), 1'b0);
            @(negedge clk);
            idle_inputs();
            repeat (3) @(negedge clk);
        end
`ifdef BLOOM_ARB_STATS_EN
        exp0 = 32'd5; exp1 = 32'd3;
`else
        exp0 = 32'd0; exp1 = 32'd0;
`endif
        n_tests++;
        if (gnt_cnt0 !== exp0 || gnt_cnt1 !== exp1) begin
            n_fail++; $display("FAIL stats_counts: got %0d/%0d, required %0d/%0d", gnt_cnt0, gnt_cnt1, exp0, exp1);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] act, expv;
        logic [31:0]   ec0, ec1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
`ifdef BLOOM_ARB_STATS_EN
            ec0 = m_cnt[0]; ec1 = m_cnt[1];
`else
            ec0 = 0; ec1 = 0;
`endif
            act  = {core_wr, core_clr, core_idx0, core_idx1, core_tuple, core_is_ack, core_src,
                    req0_rdy, req1_rdy, clear_busy, clear_done, gnt_cnt0, gnt_cnt1};
            expv = {e_wr, e_clr, e_i0, e_i1, e_tup, e_ack, e_src,
                    ~mh[0].v, ~mh[1].v, m_pend, e_done, ec0, ec1};
            n_tests++;
            if (act !== expv) begin
                n_fail++; $display("FAIL random_cycle[%0d]: got %h, required %h", c, act, expv);
            end
            req0_wr = $urandom_range(0, 1); req0_idx0 = HB'($urandom); req0_idx1 = HB'($urandom);
            req0_tuple = rand_tuple(); req0_is_ack = $urandom_range(0, 1);
            req1_wr = $urandom_range(0, 1); req1_idx0 = HB'($urandom); req1_idx1 = HB'($urandom);
            req1_tuple = rand_tuple(); req1_is_ack = $urandom_range(0, 1);
            core_rdy  = ($urandom_range(0, 3) != 0);
            clear_req = ($urandom_range(0, 199) == 0);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1; core_rdy = 1; idle_inputs();
        req0_idx0 = '0; req0_idx1 = '0; req0_tuple = '0; req0_is_ack = 0;
        req1_idx0 = '0; req1_idx1 = '0; req1_tuple = '0; req1_is_ack = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
